tx_fcs_ctrl: RTL and testbench

TX_FCS_CTRL -- requirements
Module: tx_fcs_ctrl

---
 rtl/tx_fcs_ctrl.sv | 155 +++++++++++++++
 tb/tb_tx_fcs_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_fcs_ctrl.sv
// Ethernet TX FCS appender: passes AXI-Stream frames through one register stage,
// drives an external CRC32 engine and appends the 4-byte FCS after the last data byte.
module tx_fcs_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] o_crc_data,
    output logic [DATA_WIDTH-1:0] o_crc_state,
    output logic [KEEP_WIDTH-1:0] o_crc_data_valid,
    input  logic [DATA_WIDTH-1:0] i_crc,
    input  logic [DATA_WIDTH-1:0] i_crc_state_next,
    output logic                  o_keep_err,
    output logic                  o_frame_done
);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_TAIL} state_e;

    state_e                state_q,      state_d;
    logic [DATA_WIDTH-1:0] crc_state_q,  crc_state_d;
    logic [DATA_WIDTH-1:0] out_data_q,   out_data_d;
    logic [KEEP_WIDTH-1:0] out_keep_q,   out_keep_d;
    logic                  out_valid_q,  out_valid_d;
    logic                  out_last_q,   out_last_d;
    logic [DATA_WIDTH-1:0] tail_data_q,  tail_data_d;
    logic [KEEP_WIDTH-1:0] tail_keep_q,  tail_keep_d;

    logic                  keep_legal;
    logic [KEEP_WIDTH-1:0] crc_keep;
    logic                  accept;
    logic                  out_fire;

    // Handshake and CRC-engine side; kept apart from next-state logic to avoid a comb loop via i_crc
    always_comb begin
        if (s_axis_tlast) begin
            keep_legal = (s_axis_tkeep == 4'b0001) || (s_axis_tkeep == 4'b0011) ||
                         (s_axis_tkeep == 4'b0111) || (s_axis_tkeep == 4'b1111);
        end else begin
            keep_legal = (s_axis_tkeep == 4'b1111);
        end
        crc_keep         = keep_legal ? s_axis_tkeep : 4'b1111;
        s_axis_tready    = (state_q != ST_TAIL) && (!out_valid_q || m_axis_tready);
        accept           = s_axis_tvalid && s_axis_tready;
        out_fire         = out_valid_q && m_axis_tready;
        o_crc_data       = s_axis_tdata;
        o_crc_state      = crc_state_q;
        o_crc_data_valid = crc_keep;
        o_keep_err       = accept && !keep_legal && !i_reset;
        o_frame_done     = out_fire && out_last_q;
    end

    always_comb begin
        state_d     = state_q;
        crc_state_d = crc_state_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        tail_data_d = tail_data_q;
        tail_keep_d = tail_keep_q;

        case (state_q)
            ST_IDLE, ST_DATA: begin
                if (accept && !s_axis_tlast) begin
                    out_data_d  = s_axis_tdata;
                    out_keep_d  = s_axis_tkeep;
                    out_last_d  = 1'b0;
                    out_valid_d = 1'b1;
                    crc_state_d = i_crc_state_next;
                    state_d     = ST_DATA;
                end else if (accept) begin
                    // Last beat: FCS fills the free upper lanes, the rest goes to the tail beat
                    out_keep_d  = 4'b1111;
                    out_last_d  = 1'b0;
                    out_valid_d = 1'b1;
                    crc_state_d = '1;
                    state_d     = ST_TAIL;
                    case (crc_keep)
                        4'b0001: begin
                            out_data_d  = {i_crc[23:0], s_axis_tdata[7:0]};
                            tail_data_d = {24'd0, i_crc[31:24]};
                            tail_keep_d = 4'b0001;
                        end
                        4'b0011: begin
                            out_data_d  = {i_crc[15:0], s_axis_tdata[15:0]};
                            tail_data_d = {16'd0, i_crc[31:16]};
                            tail_keep_d = 4'b0011;
                        end
                        4'b0111: begin
                            out_data_d  = {i_crc[7:0], s_axis_tdata[23:0]};
                            tail_data_d = {8'd0, i_crc[31:8]};
                            tail_keep_d = 4'b0111;
                        end
                        default: begin
                            out_data_d  = s_axis_tdata;
                            tail_data_d = i_crc;
                            tail_keep_d = 4'b1111;
                        end
                    endcase
                end else if (out_fire) begin
                    out_valid_d = 1'b0;
                end
            end
            ST_TAIL: begin
                if (out_fire) begin
                    out_data_d  = tail_data_q;
                    out_keep_d  = tail_keep_q;
                    out_last_d  = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            crc_state_q <= '1;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            tail_data_q <= '0;
            tail_keep_q <= '0;
        end else begin
            state_q     <= state_d;
            crc_state_q <= crc_state_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            tail_data_q <= tail_data_d;
            tail_keep_q <= tail_keep_d;
        end
    end

    assign m_axis_tdata  = out_data_q;
    assign m_axis_tkeep  = out_keep_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tlast  = out_last_q;

endmodule

// File: tb/tb_tx_fcs_ctrl.sv
// Bench for tx_fcs_ctrl: bytewise CRC32 engine model, frame-level FCS reference,
// directed known-answer frames plus randomized frames with random back-pressure.
module tb_tx_fcs_ctrl;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic [31:0] o_crc_data;
    logic [31:0] o_crc_state;
    logic [3:0]  o_crc_data_valid;
    logic [31:0] i_crc;
    logic [31:0] i_crc_state_next;
    logic        o_keep_err;
    logic        o_frame_done;

    int checks = 0;
    int errors = 0;

    beat_t      in_q[$];
    beat_t      exp_q[$];
    bit         err_q[$];
    logic [7:0] frame_b[$];

    always #5 clk = ~clk;

    tx_fcs_ctrl #(.DATA_WIDTH(32), .KEEP_WIDTH(4)) dut (
        .i_clk            (clk),
        .i_reset          (i_reset),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tkeep     (s_axis_tkeep),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tready    (s_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tkeep     (m_axis_tkeep),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tready    (m_axis_tready),
        .o_crc_data       (o_crc_data),
        .o_crc_state      (o_crc_state),
        .o_crc_data_valid (o_crc_data_valid),
        .i_crc            (i_crc),
        .i_crc_state_next (i_crc_state_next),
        .o_keep_err       (o_keep_err),
        .o_frame_done     (o_frame_done)
    );

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] x;
        x = c ^ {24'd0, b};
        for (int k = 0; k < 8; k++) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        return x;
    endfunction

    // External CRC32 engine: consumes the enabled byte lanes in wire order
    always_comb begin
        logic [31:0] st;
        st = o_crc_state;
        for (int i = 0; i < 4; i++) if (o_crc_data_valid[i]) st = crc_byte(st, o_crc_data[8*i +: 8]);
        i_crc_state_next = st;
        i_crc            = ~st;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Queue input beats of frame_b; optionally queue the reference output (bytes + FCS in 4-byte beats)
    task automatic add_frame(input bit model, input int bad_beat, input logic [3:0] bad_keep);
        int          len;
        int          nb;
        int          n;
        logic [31:0] c;
        logic [31:0] fcs;
        logic [7:0]  all_b[$];
        beat_t       b;
        len = frame_b.size();
        nb  = (len + 3) / 4;
        for (int i = 0; i < nb; i++) begin
            n      = (len - 4 * i) > 4 ? 4 : len - 4 * i;
            b.data = $urandom;
            for (int j = 0; j < n; j++) b.data[8*j +: 8] = frame_b[4*i + j];
            b.last = (i == nb - 1);
            b.keep = (i == bad_beat) ? bad_keep : 4'((1 << n) - 1);
            in_q.push_back(b);
            err_q.push_back(i == bad_beat);
        end
        if (model) begin
            c = '1;
            foreach (frame_b[i]) c = crc_byte(c, frame_b[i]);
            fcs   = ~c;
            all_b = frame_b;
            for (int k = 0; k < 4; k++) all_b.push_back(fcs[8*k +: 8]);
            nb = (all_b.size() + 3) / 4;
            for (int i = 0; i < nb; i++) begin
                n      = (all_b.size() - 4 * i) > 4 ? 4 : all_b.size() - 4 * i;
                b.data = '0;
                for (int j = 0; j < n; j++) b.data[8*j +: 8] = all_b[4*i + j];
                b.last = (i == nb - 1);
                b.keep = (i == bad_beat) ? bad_keep : 4'((1 << n) - 1);
                exp_q.push_back(b);
            end
        end
        frame_b.delete();
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t b;
        b.data = d; b.keep = k; b.last = l;
        exp_q.push_back(b);
    endtask

    // rmode: 0 always ready, 1 ready pattern 1,0,0,1, 2 random; vmode: 0 continuous, 1 random gaps
    task automatic run(input int rmode, input int vmode);
        int    budget;
        int    rcnt;
        logic  stall;
        logic  prev_last_acc;
        logic  acc;
        beat_t held;
        beat_t e;
        budget = 0; rcnt = 0; stall = 1'b0; prev_last_acc = 1'b0; held = '0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && budget < 3000) begin
            @(negedge clk);
            budget++;
            case (rmode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
                default: m_axis_tready = ($urandom_range(0, 2) != 0);
            endcase
            rcnt++;
            if (in_q.size() != 0 && (vmode == 0 || $urandom_range(0, 3) != 0)) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = in_q[0].data;
                s_axis_tkeep  = in_q[0].keep;
                s_axis_tlast  = in_q[0].last;
            end else begin
                s_axis_tvalid = 1'b0;
                s_axis_tdata  = $urandom;
                s_axis_tkeep  = 4'($urandom);
                s_axis_tlast  = 1'b0;
            end
            #1;
            if (stall) begin
                chk("hold_valid", 32'(m_axis_tvalid), 32'd1);
                chk("hold_data",  m_axis_tdata, held.data);
                chk("hold_keep",  32'(m_axis_tkeep), 32'(held.keep));
                chk("hold_last",  32'(m_axis_tlast), 32'(held.last));
            end
            if (rmode == 0) chk("s_ready", 32'(s_axis_tready), 32'(!prev_last_acc));
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", m_axis_tdata, e.data);
                    chk("out_keep", 32'(m_axis_tkeep), 32'(e.keep));
                    chk("out_last", 32'(m_axis_tlast), 32'(e.last));
                    chk("frame_done", 32'(o_frame_done), 32'(e.last));
                end
            end else begin
                chk("frame_done_idle", 32'(o_frame_done), 32'd0);
            end
            acc = s_axis_tvalid && s_axis_tready;
            if (acc) begin
                chk("keep_err", 32'(o_keep_err), 32'(err_q[0]));
                void'(in_q.pop_front());
                void'(err_q.pop_front());
            end else begin
                chk("keep_err_idle", 32'(o_keep_err), 32'd0);
            end
            prev_last_acc = acc && s_axis_tlast;
            stall = m_axis_tvalid && !m_axis_tready;
            held  = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
        end
        chk("pending_after_budget", 32'(exp_q.size() + in_q.size()), 32'd0);
        in_q.delete(); exp_q.delete(); err_q.delete();
        s_axis_tvalid = 1'b0;
    endtask

    initial begin
        int len;
        int nbeats;
        int bad;
        logic [3:0] bk;
        i_reset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
        s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tlast",  32'(m_axis_tlast), 32'd0);
        chk("rst_tdata",  m_axis_tdata, 32'd0);
        chk("rst_tkeep",  32'(m_axis_tkeep), 32'd0);
        chk("rst_crc_state", o_crc_state, 32'hFFFFFFFF);
        chk("rst_frame_done", 32'(o_frame_done), 32'd0);
        i_reset = 1'b0;
        #1;
        chk("rst_s_ready", 32'(s_axis_tready), 32'd1);

        // "123456789", always ready, then with ready 1,0,0,1
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 9; i++) frame_b.push_back(8'(8'h31 + i));
            add_frame(1'b0, -1, 4'h0);
            push_exp(32'h34333231, 4'hF, 1'b0);
            push_exp(32'h38373635, 4'hF, 1'b0);
            push_exp(32'hF4392639, 4'hF, 1'b0);
            push_exp(32'h000000CB, 4'h1, 1'b1);
            run(r, 0);
        end

        // Two back-to-back single-beat zero frames
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 4; i++) frame_b.push_back(8'h00);
            add_frame(1'b0, -1, 4'h0);
            push_exp(32'h00000000, 4'hF, 1'b0);
            push_exp(32'h2144DF1C, 4'hF, 1'b1);
        end
        run(0, 0);

        // Illegal keep on a non-last beat: passes through, CRC covers all four bytes
        for (int i = 0; i < 10; i++) frame_b.push_back(8'($urandom));
        add_frame(1'b1, 0, 4'b0101);
        run(0, 0);

        // Reset while the FCS tail is pending
        @(negedge clk);
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1; s_axis_tdata = '0; s_axis_tkeep = 4'hF; s_axis_tlast = 1'b1;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        #1;
        chk("tail_valid", 32'(m_axis_tvalid), 32'd1);
        chk("tail_s_ready", 32'(s_axis_tready), 32'd0);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        #1;
        chk("tail_rst_valid", 32'(m_axis_tvalid), 32'd0);
        chk("tail_rst_s_ready", 32'(s_axis_tready), 32'd1);
        chk("tail_rst_crc_state", o_crc_state, 32'hFFFFFFFF);
        for (int i = 0; i < 4; i++) frame_b.push_back(8'h00);
        add_frame(1'b0, -1, 4'h0);
        push_exp(32'h00000000, 4'hF, 1'b0);
        push_exp(32'h2144DF1C, 4'hF, 1'b1);
        run(0, 0);

        // Randomized frames with random gaps and back-pressure
        for (int f = 0; f < 30; f++) begin
            len    = $urandom_range(1, 24);
            nbeats = (len + 3) / 4;
            for (int i = 0; i < len; i++) frame_b.push_back(8'($urandom));
            bad = -1;
            bk  = 4'h0;
            if (nbeats > 1 && $urandom_range(0, 3) == 0) begin
                bad = $urandom_range(0, nbeats - 2);
                bk  = 4'($urandom_range(0, 14));
            end
            add_frame(1'b1, bad, bk);
        end
        run(2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
